// File: rtl/rbr_to_tc_conv_if.sv
// Handshake bundle for the RBR-to-two's-complement converter.
//   master : upstream/downstream side (testbench or datapath) driving operands and accepting
//            results.
//   slave  : the converter itself.
// Signals:
//   in_valid/in_ready  operand handshake, rbr carries the 2*W-bit RBR operand.
//   out_valid/out_ready result handshake, tc carries the (W+1)-bit two's-complement result.
//   zero               result-is-zero flag, present only with RBR_TO_TC_ZERO_FLAG_EN.
interface rbr_to_tc_conv_if #(
    parameter int unsigned W = 64
) ();
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] rbr;
    logic           out_valid;
    logic           out_ready;
    logic [W:0]     tc;
`ifdef RBR_TO_TC_ZERO_FLAG_EN
    logic           zero;

    modport master (
        output in_valid, rbr, out_ready,
        input  in_ready, out_valid, tc, zero
    );
    modport slave (
        input  in_valid, rbr, out_ready,
        output in_ready, out_valid, tc, zero
    );
`else
    modport master (
        output in_valid, rbr, out_ready,
        input  in_ready, out_valid, tc
    );
    modport slave (
        input  in_valid, rbr, out_ready,
        output in_ready, out_valid, tc
    );
`endif
endinterface

// File: rtl/rbr_to_tc_conv.sv
// Multi-cycle RBR to two's-complement converter. The W-digit RBR operand is split into
// positive (P) and negative (N) bit vectors, and P - N is computed C bits per cycle with a
// registered borrow, so result = {borrow_out_of_msb_chunk, (P - N) mod 2^W}.
// Ports:
//   clk  rising-edge clock
//   arst asynchronous active-high reset
//   bus  rbr_to_tc_conv_if.slave: in_valid/in_ready/rbr operand side,
//        out_valid/out_ready/tc result side, zero flag when enabled.
// Optional feature: define RBR_TO_TC_ZERO_FLAG_EN to add the registered `zero` result flag.
module rbr_to_tc_conv #(
    parameter int unsigned W = 64,
    parameter int unsigned C = 16
) (
    input logic             clk,
    input logic             arst,
    rbr_to_tc_conv_if.slave bus
);
    localparam int unsigned NumChunks = W / C;
    localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumChunks - 1);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    p_q, p_d, n_q, n_d, res_q, res_d;
    logic            borrow_q, borrow_d, bfin_q, bfin_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [W-1:0]    p_in, n_in;
    logic [C:0]      diff;
    logic [C-1:0]    d;
    logic            b_out;
    logic [W-1:0]    d_wide;
    logic            ready_raw;
    logic            accept;
    logic            last_chunk;

    always_comb begin
        p_in = '0;
        n_in = '0;
        for (int i = 0; i < W; i++) begin
            p_in[i] = bus.rbr[2*i+1] & bus.rbr[2*i];
            n_in[i] = ~bus.rbr[2*i+1] & ~bus.rbr[2*i];
        end
    end

    // One extra bit on the subtract so the chunk borrow-out lands in diff[C].
    assign diff       = {1'b0, p_q[C-1:0]} - {1'b0, n_q[C-1:0]} - {{C{1'b0}}, borrow_q};
    assign d          = diff[C-1:0];
    assign b_out      = diff[C];
    assign d_wide     = W'(d) << (W - C);
    assign last_chunk = (cnt_q == LastCnt);

    always_comb begin
        ready_raw = 1'b0;
        unique case (state_q)
            StIdle:  ready_raw = 1'b1;
            StConv:  ready_raw = 1'b0;
            StDone:  ready_raw = bus.out_ready;
            default: ready_raw = 1'b0;
        endcase
    end

    // Hold in_ready low while reset is asserted even though the state already reads idle.
    assign bus.in_ready  = ready_raw & ~arst;
    assign accept        = ready_raw & bus.in_valid;
    assign bus.out_valid = (state_q == StDone);
    assign bus.tc        = {bfin_q, res_q};

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        n_d      = n_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        bfin_d   = bfin_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: ;
            StConv: begin
                p_d      = p_q >> C;
                n_d      = n_q >> C;
                res_d    = (res_q >> C) | d_wide;
                borrow_d = b_out;
                cnt_d    = cnt_q + CntW'(1);
                if (last_chunk) begin
                    bfin_d  = b_out;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready && !bus.in_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Accept overrides: covers both idle start and the same-edge reload from done.
        if (accept) begin
            p_d      = p_in;
            n_d      = n_in;
            borrow_d = 1'b0;
            cnt_d    = '0;
            state_d  = StConv;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= StIdle;
            p_q      <= '0;
            n_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            bfin_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            n_q      <= n_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            bfin_q   <= bfin_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef RBR_TO_TC_ZERO_FLAG_EN
    // nz accumulates "some result chunk was nonzero"; zero is latched on the final chunk.
    logic nz_q, nz_d, zero_q, zero_d;

    always_comb begin
        nz_d   = nz_q;
        zero_d = zero_q;
        if (accept) begin
            nz_d = 1'b0;
        end else if (state_q == StConv) begin
            nz_d = nz_q | (|d);
            if (last_chunk) begin
                zero_d = ~(nz_q | (|d)) & ~b_out;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            nz_q   <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            nz_q   <= nz_d;
            zero_q <= zero_d;
        end
    end

    assign bus.zero = zero_q;
`endif
endmodule

// File: tb/tb_rbr_to_tc_conv.sv
// Self-checking bench for rbr_to_tc_conv with W = 8, C = 4 (latency 2, one result per 3 cycles).
// Directed vectors come from a table; every accepted operand pushes its expected result into a
// scoreboard queue which a monitor pops when the result handshake completes.
module tb_rbr_to_tc_conv;
    localparam int W = 8;
    localparam int C = 4;

    typedef struct packed {
        logic [W:0] tc;
        logic       zero;
    } exp_t;

    typedef struct packed {
        logic [2*W-1:0] rbr;
        logic [W:0]     tc;
        logic           zero;
    } vec_t;

    logic clk = 1'b0;
    logic arst;
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    exp_t sb_q[$];
    int   out_cycles[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    rbr_to_tc_conv_if #(.W(W)) bus ();

    rbr_to_tc_conv #(.W(W), .C(C)) dut (
        .clk (clk),
        .arst(arst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent model: signed digit sum.
    function automatic exp_t model(input logic [2*W-1:0] r);
        int   v;
        exp_t e;
        logic [31:0] vb;
        v = 0;
        for (int i = 0; i < W; i++) begin
            if (r[2*i+:2] == 2'b00) v -= (1 << i);
            else if (r[2*i+:2] == 2'b11) v += (1 << i);
        end
        vb     = v;
        e.tc   = vb[W:0];
        e.zero = (v == 0);
        return e;
    endfunction

    // Monitor: a result handshake completes on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!arst && bus.out_valid && bus.out_ready) begin
            out_cycles.push_back(cycle);
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'(bus.tc), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("sb_tc", 32'(bus.tc), 32'(e.tc));
`ifdef RBR_TO_TC_ZERO_FLAG_EN
                check("sb_zero", 32'(bus.zero), 32'(e.zero));
`endif
            end
        end
    end

    // Called at 1ns after a rising edge; returns 1ns after the accepting edge.
    task automatic send(input logic [2*W-1:0] r, input exp_t e);
        int n;
        n = 0;
        bus.rbr      = r;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back(e);
                break;
            end
            n++;
            if (n > 50) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.rbr      = 16'($urandom);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        exp_t e;
        logic [2*W-1:0] r;
        int seen;

        vecs[0] = '{rbr: 16'hFFFF, tc: 9'h0FF, zero: 1'b0};
        vecs[1] = '{rbr: 16'h0000, tc: 9'h101, zero: 1'b0};
        vecs[2] = '{rbr: 16'h5556, tc: 9'h000, zero: 1'b1};
        vecs[3] = '{rbr: 16'h4003, tc: 9'h183, zero: 1'b0};
        vecs[4] = '{rbr: 16'hAAAA, tc: 9'h000, zero: 1'b1};
        vecs[5] = '{rbr: 16'h0003, tc: 9'h103, zero: 1'b0};
        vecs[6] = '{rbr: 16'hC000, tc: 9'h001, zero: 1'b0};

        arst          = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.rbr       = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_tc", 32'(bus.tc), 32'd0);
`ifdef RBR_TO_TC_ZERO_FLAG_EN
        check("rst_zero", 32'(bus.zero), 32'd0);
`endif
        @(posedge clk);
        #1;
        arst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            e.tc   = vecs[i].tc;
            e.zero = vecs[i].zero;
            send(vecs[i].rbr, e);
            wait_drain("table_drain");
        end

        // Latency: accept edge k, out_valid visible only after edge k+2.
        send(16'h4003, model(16'h4003));
        @(negedge clk);
        check("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
        check("lat_cycle1_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle3_valid", 32'(bus.out_valid), 32'd1);
        wait_drain("lat_drain");

        // Backpressure in DONE, then release with a new operand on the same edge.
        bus.out_ready = 1'b0;
        send(16'h0000, model(16'h0000));
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_tc", 32'(bus.tc), 32'h101);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(16'hFFFF, model(16'hFFFF));
        check("bp_sb_depth", 32'(sb_q.size()), 32'd1);
        @(negedge clk);
        check("bp_reload_conv", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        wait_drain("bp_drain");

        // Back-to-back random stream.
        out_cycles.delete();
        for (int i = 0; i < 10; i++) begin
            r = 16'($urandom);
            send(r, model(r));
        end
        wait_drain("stream_drain");
        check("stream_count", 32'(out_cycles.size()), 32'd10);
        for (int i = 1; i < out_cycles.size(); i++) begin
            check("stream_spacing", 32'(out_cycles[i] - out_cycles[i-1]), 32'd3);
        end

        // Reset during the second CONV cycle aborts the conversion.
        send(16'hFFFF, model(16'hFFFF));
        @(posedge clk);
        #1;
        arst = 1'b1;
        @(negedge clk);
        check("arst_in_ready", 32'(bus.in_ready), 32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
            check("post_arst_in_ready", 32'(bus.in_ready), 32'd1);
        end
        check("arst_no_out_valid", 32'(seen), 32'd0);
        check("arst_result_pending", 32'(sb_q.size()), 32'd1);
        sb_q.delete();
        @(posedge clk);
        #1;
        send(16'h4003, model(16'h4003));
        wait_drain("post_arst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rbr_to_tc_conv.md
# rbr_to_tc_conv

Multi-cycle converter from Redundant Binary Representation (RBR) to two's complement. It sits directly downstream of the RBR adder/subtractor in the BKM FPU datapath and turns the W-digit RBR sum into a (W+1)-bit two's-complement word for normalisation and rounding. Conversion runs C digits per cycle with a registered borrow chain, so the full-width carry-propagate subtract never appears in one cycle. Valid/ready handshakes on both sides.

## Interface
- W, default 64: RBR digit count; input is 2*W bits, output is W+1 bits.
- C, default 16: digits converted per cycle; W must be a multiple of C, and C is at least 1.
- clk  input  1  clock; all state updates on the rising edge.
- arst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  `rbr` holds an operand.
- in_ready  output  1  block accepts an operand this cycle.
- rbr  input  2*W  RBR operand. Digit i is rbr[2i+1:2i]: 00 = -1, 01 = 0, 10 = 0, 11 = +1.
- out_valid  output  1  `tc` holds a result.
- out_ready  input  1  consumer takes the result this cycle.
- tc  output  W+1  two's-complement value of the operand.
- zero  output  1  only with RBR_TO_TC_ZERO_FLAG_EN; result equals 0.

## Operation
- Digit split: p[i] = rbr[2i+1] & rbr[2i]; n[i] = ~rbr[2i+1] & ~rbr[2i]. Value = P - N, with P and N each W-bit unsigned.
- Result: tc = {b_final, D}. D = (P - N) mod 2^W. b_final is the borrow out of the MSB chunk, which is 1 exactly when P < N.
- Range: -(2^W-1)..+(2^W-1). The result always fits, so there is no overflow case.
- FSM states and transitions:
  - IDLE: in_ready = 1, out_valid = 0. When in_valid is high, latch P and N into shift registers, clear borrow, clear chunk counter, go to CONV.
  - CONV: each cycle compute {b_out, d} = P[C-1:0] - N[C-1:0] - borrow, where d is C bits.
    - Shift d into the result register from the MSB side.
    - Shift P and N right by C; borrow <= b_out; counter++.
    - When counter reaches W/C-1, load tc[W] <= b_out and go to DONE.
    - in_ready = 0 throughout CONV.
  - DONE: out_valid = 1; tc is stable until accepted.
    - out_ready = 1 and in_valid = 0: go to IDLE.
    - out_ready = 1 and in_valid = 1: handshake completes and the new operand is latched in the same cycle; go to CONV. In DONE, in_ready = out_ready.
    - out_ready = 0: hold all state.
- The rbr input is sampled only at the accept edge. Later changes on rbr have no effect.
- Counter width is clog2(W/C), with a minimum of 1 bit.
- Case C == W: CONV lasts exactly one cycle.

## Timing
- Reset values: in_ready = 0 during arst, then 1 from the first cycle in IDLE. out_valid = 0, tc = 0, zero = 0, state = IDLE, borrow = 0, counter = 0.
- Latency: operand accepted at edge k gives out_valid = 1 after edge k+W/C.
- Throughput: one result per W/C+1 cycles under back-to-back traffic with out_ready held at 1.
- Outputs are registered. in_ready is combinational from state and out_ready. There is no path from in_valid to in_ready.
- arst asserted mid-CONV or in DONE: abort immediately to IDLE with reset values. The partial or pending result is discarded and no out_valid pulse is produced.

## Configuration
- RBR_TO_TC_ZERO_FLAG_EN defined:
  - `zero` port present, registered when entering DONE.
  - It equals (D == 0) && !b_final, accumulated per chunk as an OR of d.
  - Valid only while out_valid = 1.
- Not defined: no `zero` port and no accumulation logic. All other behaviour is identical.

## Test plan
Parameters for all scenarios: W = 8, C = 4, so latency is 2.
- All digits 11 (rbr = 16'hFFFF) -> tc = 9'h0FF (+255), zero = 0.
- All digits 00 (rbr = 16'h0000) -> tc = 9'h101 (-255).
- Mixed digits: rbr = 16'h5556 (digits 01 except digit 0 = 10) -> tc = 9'h000, zero = 1. Then rbr = 16'h4003 (digit 7 = 01, digits 6..1 = 00, digit 0 = 11), value -126+1 = -125 -> tc = 9'h183.
- Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid and tc stay stable and in_ready = 0; releasing out_ready with in_valid = 1 accepts the next operand on the same edge.
- Back-to-back stream of 10 random operands with out_ready = 1 -> results in order, each matching P - N, one result every 3 cycles.
- arst pulsed on the second CONV cycle -> out_valid never rises for that operand. After release, in_ready = 1 and a fresh operand converts correctly.
